sap1_run_ctrl: RTL and testbench
================================

// Module: sap1_run_ctrl
// PURPOSE
//  Run/clock controller for the SAP-1 datapath. Conditions the front-panel controls
//  (clear/start pushbutton, manual/auto switch, single-step pushbutton).
//  Sequences the machine through clear, manual single-step, free-run and halt.
//  Emits a one-cycle clock-enable that every SAP-1 register (PC, ring counter, A/B, IR,
//  MAR, OUT) qualifies on sap_base_clock. Sits between the top-level pins and the core.
// PARAMETERS
//  DEBOUNCE_CYC  50000     consecutive stable samples before a debounced input changes (>=1)
//  AUTO_DIV      5000000   base-clock cycles per clk_en pulse in auto mode (>=1)
//  CLR_STRETCH   16        minimum cycles sap_clr stays high per clear event (>=1)
// PORTS
//  sap_base_clock     in   1  system clock; all logic on rising edge
//  sap_rst_n          in   1  asynchronous, active-low reset
//  sap_CleanStart_pb  in   1  raw pushbutton: 0 = clear pressed, 1 = released/start
//  sap_ManualAuto_sw  in   1  raw switch: 0 = manual, 1 = auto
//  sap_SingleStep_pb  in   1  raw pushbutton: 1 = pressed
//  sap_hlt            in   1  HLT decoded by control sequencer, synchronous, level
//  sap_clk_en         out  1  one-cycle advance strobe to datapath
//  sap_clr            out  1  active-high clear to PC, ring counter, registers
//  sap_running        out  1  1 in MANUAL or AUTO state
//  sap_halted         out  1  1 in HALT state
//  sap_mode_auto      out  1  debounced manual/auto switch value
// BEHAVIOUR
//  - Reset (async, immediate): clk_en=0, clr=1, running=0, halted=0, mode_auto=1.
//    State=CLEAR; debounced values: clear=1, mode=1, step=0. All counters=0.
//  - Input conditioning: each raw input passes through a 2-FF synchronizer, then a debouncer.
//    The debounced value takes the synced value after DEBOUNCE_CYC consecutive equal
//    samples differing from it. Any mismatch restarts the count.
//    Pin change to debounced change latency = 2+DEBOUNCE_CYC cycles.
//  - All outputs registered: clk_en asserts 1 cycle after its triggering condition.
//  - FSM states: CLEAR, MANUAL, AUTO, HALT. Priority each cycle: clear press > hlt > mode/step.
//    CLEAR: clr=1, clk_en=0. A stretch counter counts cycles in CLEAR. Exit when
//      db_clear=1 and count>=CLR_STRETCH, to AUTO if db_mode=1, else MANUAL.
//      The stretch counter zeroes on entry.
//    MANUAL: clk_en pulses once per debounced step rising edge (0->1). Holding gives one pulse.
//      db_mode=1 -> AUTO with divider=0; no pulse that cycle.
//    AUTO: divider counts 0..AUTO_DIV-1 and wraps. clk_en pulses when divider==AUTO_DIV-1.
//      First pulse = AUTO_DIV cycles after entry; AUTO_DIV=1 pulses every cycle.
//      db_mode=0 -> MANUAL, divider cleared. Step edges are ignored.
//    HALT: clk_en=0, halted=1. Mode and step are ignored. Only a clear press exits (-> CLEAR).
//  - Clear press = db_clear falling 1->0, from any state. Next state is CLEAR and no clk_en that cycle.
//    Holding clear keeps the FSM in CLEAR regardless of the stretch counter.
//  - sap_hlt=1 in MANUAL/AUTO -> HALT next cycle. A clk_en due that cycle is suppressed.
//  - The step edge detector updates in every state. A step held across a mode change
//    or across clear does not fire; a fresh press is required.
//  - sap_mode_auto mirrors db_mode in every state.
//  - Reset asserted mid-operation overrides everything; behaviour is as the reset values.
// TESTING (bench: DEBOUNCE_CYC=4, AUTO_DIV=8, CLR_STRETCH=3, 20 ns clock)
//  1. Release rst_n, pb=1, mode=1 -> clr=1 for >=3 cycles, then running=1.
//     clk_en every 8th cycle: exactly 4 pulses in the 32 cycles after entering AUTO.
//  2. mode=0; 5 step presses of 10 cycles high / 10 low -> exactly 5 single-cycle clk_en.
//     A 2-cycle step glitch -> 0 pulses.
//  3. In AUTO, assert hlt on the divider==7 cycle -> no clk_en, halted=1, running=0.
//     Then 3 step presses and mode toggles -> 0 pulses.
//     Then clear pulse -> clr=1, halted=0, later running=1.
//  4. Clear pressed mid-AUTO -> clr=1 within 2+4+1 cycles, clk_en=0 for the whole press.
//     Release -> first clk_en exactly 8 cycles after AUTO re-entry.
//  5. Step held high while switching auto->manual -> 0 pulses.
//     Release and press again -> exactly 1 pulse.
//  6. Drop rst_n mid-AUTO, between clock edges -> outputs immediately at reset values.
//     No clk_en while rst_n=0.

Source files
------------

// File: rtl/sap1_run_ctrl.sv
// ----------------------------------------------------------------------------
// sap1_run_ctrl
//   Run/clock controller for the SAP-1 datapath. Synchronizes and debounces the
//   front-panel controls, sequences the machine through clear, manual
//   single-step, free-run and halt, and emits a one-cycle advance strobe
//   (sap_clk_en) that every SAP-1 register qualifies on sap_base_clock.
//
// Parameters
//   DEBOUNCE_CYC  consecutive stable samples before a debounced input changes
//   AUTO_DIV      base-clock cycles per sap_clk_en pulse in auto mode
//   CLR_STRETCH   minimum cycles spent in clear per clear event
//
// Ports
//   sap_base_clock     in   system clock, rising edge
//   sap_rst_n          in   asynchronous active-low reset
//   sap_CleanStart_pb  in   raw pushbutton, 0 = clear pressed, 1 = released/start
//   sap_ManualAuto_sw  in   raw switch, 0 = manual, 1 = auto
//   sap_SingleStep_pb  in   raw pushbutton, 1 = pressed
//   sap_hlt            in   HLT from the control sequencer (synchronous level)
//   sap_clk_en         out  one-cycle advance strobe
//   sap_clr            out  active-high clear to PC, ring counter and registers
//   sap_running        out  1 in manual or auto state
//   sap_halted         out  1 in halt state
//   sap_mode_auto      out  debounced manual/auto switch value
// ----------------------------------------------------------------------------
module sap1_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned AUTO_DIV     = 5000000,
    parameter int unsigned CLR_STRETCH  = 16
) (
    input  logic sap_base_clock,
    input  logic sap_rst_n,
    input  logic sap_CleanStart_pb,
    input  logic sap_ManualAuto_sw,
    input  logic sap_SingleStep_pb,
    input  logic sap_hlt,
    output logic sap_clk_en,
    output logic sap_clr,
    output logic sap_running,
    output logic sap_halted,
    output logic sap_mode_auto
);

    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned DivW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam int unsigned StW  = $clog2(CLR_STRETCH + 1);

    localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYC - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(AUTO_DIV - 1);
    localparam logic [StW-1:0]  StMax   = StW'(CLR_STRETCH);

    // Input vector bit positions and their reset (idle) values.
    localparam int unsigned IClr  = 0;
    localparam int unsigned IMode = 1;
    localparam int unsigned IStep = 2;
    localparam logic [2:0]  InRst = 3'b011;

    typedef enum logic [1:0] {
        StClear,
        StManual,
        StAuto,
        StHalt
    } state_e;

    // ------------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizer followed by a run-length debouncer
    // ------------------------------------------------------------------------
    logic [2:0]     raw;
    logic [2:0]     sync1_q, sync2_q;
    logic [2:0]     db_q, db_d;
    logic [DbW-1:0] db_cnt_q [3];
    logic [DbW-1:0] db_cnt_d [3];

    assign raw = {sap_SingleStep_pb, sap_ManualAuto_sw, sap_CleanStart_pb};

    // The count tracks consecutive samples that disagree with the debounced
    // value; any agreeing sample restarts it.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    always_ff @(posedge sap_base_clock or negedge sap_rst_n) begin
        if (!sap_rst_n) begin
            sync1_q <= InRst;
            sync2_q <= InRst;
            db_q    <= InRst;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Edge detection on the debounced clear and step inputs
    // ------------------------------------------------------------------------
    logic clear_prev_q;
    logic step_prev_q;
    logic clear_press;
    logic step_rise;

    assign clear_press = clear_prev_q & ~db_q[IClr];
    assign step_rise   = db_q[IStep] & ~step_prev_q;

    // ------------------------------------------------------------------------
    // Run FSM
    // ------------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [StW-1:0]  stretch_q, stretch_d;
    logic            clk_en_q, clk_en_d;
    logic            clr_q, running_q, halted_q;

    always_comb begin
        state_d  = state_q;
        div_d    = '0;
        clk_en_d = 1'b0;

        if (clear_press) begin
            state_d = StClear;
        end else begin
            unique case (state_q)
                StClear: begin
                    if (db_q[IClr] && (stretch_q >= StMax)) begin
                        state_d = db_q[IMode] ? StAuto : StManual;
                    end
                end
                StManual: begin
                    if (sap_hlt) begin
                        state_d = StHalt;
                    end else if (db_q[IMode]) begin
                        state_d = StAuto;
                    end else begin
                        clk_en_d = step_rise;
                    end
                end
                StAuto: begin
                    if (sap_hlt) begin
                        state_d = StHalt;
                    end else if (!db_q[IMode]) begin
                        state_d = StManual;
                    end else if (div_q == DivLast) begin
                        clk_en_d = 1'b1;
                    end else begin
                        div_d = div_q + DivW'(1);
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StClear;
                end
            endcase
        end

        // Stretch counter restarts on every clear event, including a fresh
        // press while already clearing, and saturates at its exit threshold.
        stretch_d = stretch_q;
        if (state_d == StClear) begin
            if ((state_q != StClear) || clear_press) begin
                stretch_d = '0;
            end else if (stretch_q < StMax) begin
                stretch_d = stretch_q + StW'(1);
            end
        end
    end

    always_ff @(posedge sap_base_clock or negedge sap_rst_n) begin
        if (!sap_rst_n) begin
            state_q      <= StClear;
            div_q        <= '0;
            stretch_q    <= '0;
            clear_prev_q <= 1'b1;
            step_prev_q  <= 1'b0;
            clk_en_q     <= 1'b0;
            clr_q        <= 1'b1;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            stretch_q    <= stretch_d;
            clear_prev_q <= db_q[IClr];
            step_prev_q  <= db_q[IStep];
            clk_en_q     <= clk_en_d;
            clr_q        <= (state_d == StClear);
            running_q    <= (state_d == StManual) || (state_d == StAuto);
            halted_q     <= (state_d == StHalt);
        end
    end

    assign sap_clk_en    = clk_en_q;
    assign sap_clr       = clr_q;
    assign sap_running   = running_q;
    assign sap_halted    = halted_q;
    assign sap_mode_auto = db_q[IMode];

endmodule

// File: tb/tb_sap1_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sap1_run_ctrl
//   Self-checking bench for sap1_run_ctrl. A cycle-level reference model built
//   from sample windows, entry timestamps and modular arithmetic predicts all
//   outputs every cycle; directed scenarios add pulse-count checks.
// ----------------------------------------------------------------------------
module tb_sap1_run_ctrl;

    localparam int unsigned D  = 4;
    localparam int unsigned A  = 8;
    localparam int unsigned CS = 3;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic pb_clr  = 1'b1;
    logic sw_mode = 1'b1;
    logic pb_step = 1'b0;
    logic hlt     = 1'b0;
    logic clk_en, clr, running, halted, mode_auto;

    sap1_run_ctrl #(
        .DEBOUNCE_CYC (D),
        .AUTO_DIV     (A),
        .CLR_STRETCH  (CS)
    ) dut (
        .sap_base_clock    (clk),
        .sap_rst_n         (rst_n),
        .sap_CleanStart_pb (pb_clr),
        .sap_ManualAuto_sw (sw_mode),
        .sap_SingleStep_pb (pb_step),
        .sap_hlt           (hlt),
        .sap_clk_en        (clk_en),
        .sap_clr           (clr),
        .sap_running       (running),
        .sap_halted        (halted),
        .sap_mode_auto     (mode_auto)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef enum {MClear, MManual, MAuto, MHalt} mst_e;

    localparam bit [2:0] RstVal = 3'b011;  // {step, mode, clear}

    mst_e       m_st;
    int         m_cyc;
    int         m_entry;      // cycle at which the current CLEAR/AUTO period began
    bit         m_s1 [3];
    bit         m_s2 [3];
    bit         m_db [3];
    bit         m_prev [3];
    bit [D-1:0] m_win [3];    // last D synchronized samples
    bit         m_en;

    task automatic model_reset();
        m_st    = MClear;
        m_cyc   = 0;
        m_entry = 0;
        m_en    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_s1[i]   = RstVal[i];
            m_s2[i]   = RstVal[i];
            m_db[i]   = RstVal[i];
            m_prev[i] = RstVal[i];
            m_win[i]  = {D{RstVal[i]}};
        end
    endtask

    task automatic model_step();
        bit   press, rise, en;
        bit   pin [3];
        mst_e nst;
        int   n;
        n      = m_cyc + 1;
        pin[0] = pb_clr;
        pin[1] = sw_mode;
        pin[2] = pb_step;
        press  = m_prev[0] && !m_db[0];
        rise   = m_db[2] && !m_prev[2];
        en     = 1'b0;
        nst    = m_st;
        if (press) begin
            nst     = MClear;
            m_entry = n;
        end else begin
            case (m_st)
                MClear: if (m_db[0] && (n - 1 - m_entry) >= int'(CS)) begin
                    nst     = m_db[1] ? MAuto : MManual;
                    m_entry = n;
                end
                MManual: if (hlt) nst = MHalt;
                    else if (m_db[1]) begin
                        nst     = MAuto;
                        m_entry = n;
                    end else en = rise;
                MAuto: if (hlt) nst = MHalt;
                    else if (!m_db[1]) nst = MManual;
                    else en = ((n - m_entry) % int'(A)) == 0;
                default: ;
            endcase
        end
        for (int i = 0; i < 3; i++) begin
            m_prev[i] = m_db[i];
            m_win[i]  = {m_win[i][D-2:0], m_s2[i]};
            if (m_win[i] == {D{~m_db[i]}}) m_db[i] = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = pin[i];
        end
        m_st  = nst;
        m_en  = en;
        m_cyc = n;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check_eq("clk_en", clk_en, m_en);
            check_eq("clr", clr, m_st == MClear);
            check_eq("running", running, (m_st == MManual) || (m_st == MAuto));
            check_eq("halted", halted, m_st == MHalt);
            check_eq("mode_auto", mode_auto, m_db[1]);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic hold(input int n);
        repeat (n) begin
            @(negedge clk);
            pulses += int'(clk_en);
        end
    endtask

    task automatic wait_running(input string tag);
        int k = 0;
        while (!running && k < 60) begin
            hold(1);
            k++;
        end
        check_eq(tag, running, 1);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int k;
        int clr_cycles;

        #1 rst_n = 1'b0;
        hold(3);
        check_eq("reset_clr", clr, 1);
        check_eq("reset_running", running, 0);
        check_eq("reset_mode", mode_auto, 1);
        rst_n = 1'b1;

        // 1: start-up into auto, 4 pulses in 32 cycles
        clr_cycles = 0;
        k = 0;
        while (!running && k < 60) begin
            @(negedge clk);
            clr_cycles += int'(clr);
            k++;
        end
        check_eq("t1_running", running, 1);
        check_eq("t1_clr_stretch", clr_cycles >= int'(CS), 1);
        pulses = 0;
        hold(32);
        check_eq("t1_auto_pulses", pulses, 4);

        // 2: manual stepping and glitch rejection
        sw_mode = 1'b0;
        hold(D + 6);
        check_eq("t2_manual_mode", mode_auto, 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            pb_step = 1'b1;
            hold($urandom_range(D + 3, 12));
            pb_step = 1'b0;
            hold($urandom_range(D + 3, 12));
        end
        check_eq("t2_step_pulses", pulses, 5);
        pulses  = 0;
        pb_step = 1'b1;
        hold(2);
        pb_step = 1'b0;
        hold(12);
        check_eq("t2_glitch", pulses, 0);

        // 3: halt on the divider terminal cycle
        sw_mode = 1'b1;
        hold(D + 6);
        k = 0;
        while (!(m_st == MAuto && ((m_cyc + 1 - m_entry) % int'(A)) == 0) && k < 40) begin
            hold(1);
            k++;
        end
        check_eq("t3_phase_found", k < 40, 1);
        hlt    = 1'b1;
        pulses = 0;
        hold(3);
        check_eq("t3_suppressed", pulses, 0);
        check_eq("t3_halted", halted, 1);
        check_eq("t3_not_running", running, 0);
        for (int i = 0; i < 3; i++) begin
            pb_step = 1'b1;
            hold(8);
            pb_step = 1'b0;
            sw_mode = ~sw_mode;
            hold(8);
        end
        sw_mode = 1'b1;
        hold(D + 6);
        check_eq("t3_halt_ignores", pulses, 0);
        check_eq("t3_still_halted", halted, 1);
        hlt    = 1'b0;
        pb_clr = 1'b0;
        k = 0;
        while (!clr && k < 12) begin
            hold(1);
            k++;
        end
        check_eq("t3_clr", clr, 1);
        check_eq("t3_unhalted", halted, 0);
        hold(6);
        pb_clr = 1'b1;
        wait_running("t3_rerun");

        // 4: clear mid-auto
        hold($urandom_range(0, 7));
        pb_clr = 1'b0;
        k = 0;
        while (!clr && k < 12) begin
            hold(1);
            k++;
        end
        check_eq("t4_clr_latency", k <= 7 && clr, 1);
        pulses = 0;
        hold(10);
        pb_clr = 1'b1;
        wait_running("t4_rerun");
        check_eq("t4_quiet_in_clear", pulses, 0);
        k = 0;
        while (!clk_en && k < 20) begin
            hold(1);
            k++;
        end
        check_eq("t4_first_pulse", k, A);

        // 5: step held across auto->manual
        pb_step = 1'b1;
        hold(D + 6);
        sw_mode = 1'b0;
        k = 0;
        while (mode_auto && k < 20) begin
            hold(1);
            k++;
        end
        check_eq("t5_mode_manual", mode_auto, 0);
        pulses = 0;
        hold(20);
        check_eq("t5_held_no_pulse", pulses, 0);
        pb_step = 1'b0;
        hold(10);
        pb_step = 1'b1;
        hold(10);
        pb_step = 1'b0;
        hold(10);
        check_eq("t5_fresh_press", pulses, 1);

        // 6: asynchronous reset mid-auto
        sw_mode = 1'b1;
        hold(D + 6);
        hold($urandom_range(0, 7));
        @(posedge clk);
        #5 rst_n = 1'b0;
        #1;
        check_eq("t6_clk_en", clk_en, 0);
        check_eq("t6_clr", clr, 1);
        check_eq("t6_running", running, 0);
        check_eq("t6_halted", halted, 0);
        check_eq("t6_mode", mode_auto, 1);
        pulses = 0;
        hold(5);
        check_eq("t6_no_pulse_in_reset", pulses, 0);
        rst_n = 1'b1;
        wait_running("t6_rerun");

        // Randomized soak against the model
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: begin
                    pb_clr = 1'b0;
                    hold($urandom_range(1, 12));
                    pb_clr = 1'b1;
                end
                1, 2, 3: sw_mode = ~sw_mode;
                4, 5, 6, 7: begin
                    pb_step = 1'b1;
                    hold($urandom_range(1, 10));
                    pb_step = 1'b0;
                end
                8: begin
                    hlt = 1'b1;
                    hold($urandom_range(1, 3));
                    hlt = 1'b0;
                end
                default: ;
            endcase
            hold($urandom_range(1, 20));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
